// File: rtl/bn128_pkg.sv
// BN254 base-field constants, Montgomery helpers and the shared FSM state type
// used by the word-serial Montgomery multiplier (fe_mont_mul_ws).
package bn128_pkg;

   localparam int FE_BITS = 256;
   typedef logic [FE_BITS-1:0] fe_t;

   localparam fe_t P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

   localparam int MONT_WORD_BITS = 64;
   localparam int MONT_WORDS     = FE_BITS / MONT_WORD_BITS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_FINAL,
      ST_OUT
   } mont_state_t;

   // Newton iteration for P^-1 mod 2^256; each step doubles the correct low bits.
   function automatic fe_t calc_mont_factor();
      fe_t inv;
      inv = 1;
      for (int i = 0; i < 9; i++) begin
         inv = inv * (fe_t'(2) - P * inv);
      end
      return -inv;
   endfunction

   localparam fe_t MONT_FACTOR = calc_mont_factor();

   function automatic logic [MONT_WORD_BITS-1:0] mont_nprime_word();
      return MONT_FACTOR[MONT_WORD_BITS-1:0];
   endfunction

   // x * 2^256 mod P by repeated modular doubling.
   function automatic fe_t fe_to_mont(input fe_t x);
      logic [FE_BITS:0] r;
      r = {1'b0, x};
      if (r >= {1'b0, P}) r = r - {1'b0, P};
      for (int i = 0; i < FE_BITS; i++) begin
         r = r << 1;
         if (r >= {1'b0, P}) r = r - {1'b0, P};
      end
      return r[FE_BITS-1:0];
   endfunction

   localparam fe_t MONT_RECIP_SQ = fe_to_mont(fe_to_mont(fe_t'(1)));

   // Bit-serial Montgomery product a*b*2^-256 mod P.
   function automatic fe_t fe_mul_mont(input fe_t a, input fe_t b);
      logic [FE_BITS+1:0] t;
      t = '0;
      for (int i = 0; i < FE_BITS; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, P};
         t = t >> 1;
      end
      if (t >= {2'b00, P}) t = t - {2'b00, P};
      return t[FE_BITS-1:0];
   endfunction

endpackage

// File: rtl/mont_word_mac.sv
// One CIOS iteration: S = T + a_i*b, m = S*P' mod 2^w, T' = (S + m*P) >> w.
// REG_OUT=1 registers T' so the update can later be pipelined or DSP-mapped.
module mont_word_mac
   import bn128_pkg::*;
#(
   parameter int DAT_BITS = 256,
   parameter int WORD_BITS = 64,
   parameter logic [DAT_BITS-1:0] P = DAT_BITS'(bn128_pkg::P),
   parameter logic [WORD_BITS-1:0] NPRIME = WORD_BITS'(bn128_pkg::MONT_FACTOR),
   parameter bit REG_OUT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DAT_BITS:0]   t,
   input  logic [WORD_BITS-1:0] a_word,
   input  logic [DAT_BITS-1:0] b,
   output logic [DAT_BITS:0]   t_next
);

   localparam int W = DAT_BITS + WORD_BITS + 2;

   logic [W-1:0]         s;
   logic [W-1:0]         s_mp;
   logic [WORD_BITS-1:0] m;
   logic [DAT_BITS:0]    t_comb;
   logic                 unused_low;

   always_comb begin
      s      = W'(t) + W'(a_word) * W'(b);
      m      = s[WORD_BITS-1:0] * NPRIME;
      s_mp   = s + W'(m) * W'(P);
      t_comb = s_mp[WORD_BITS +: DAT_BITS+1];
   end

   // The low word of S + m*P is zero by construction of m.
   assign unused_low = |s_mp[WORD_BITS-1:0];

   generate
      if (REG_OUT) begin : g_reg
         always_ff @(posedge clk or posedge rst) begin
            if (rst) t_next <= '0;
            else     t_next <= t_comb;
         end
      end else begin : g_comb
         logic unused_clk;
         assign unused_clk = clk ^ rst;
         assign t_next     = t_comb;
      end
   endgenerate

endmodule

// File: rtl/fe_mont_mul_ws.sv
// Word-serial Montgomery multiplier: a*b*2^-DAT_BITS mod P, one a-word per cycle.
// Optional build macro FE_MONT_MUL_SELF_CHECK_EN adds a behavioural result check on o_err.
module fe_mont_mul_ws
   import bn128_pkg::*;
#(
   parameter int DAT_BITS = 256,
   parameter int WORD_BITS = 64,
   parameter logic [DAT_BITS-1:0] P = DAT_BITS'(bn128_pkg::P),
   parameter logic [DAT_BITS-1:0] MONT_FACTOR = DAT_BITS'(bn128_pkg::MONT_FACTOR),
   parameter int TAG_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DAT_BITS-1:0] i_a,
   input  logic [DAT_BITS-1:0] i_b,
   input  logic [TAG_BITS-1:0] i_tag,
   input  logic                i_val,
   output logic                o_rdy,
   output logic [DAT_BITS-1:0] o_dat,
   output logic [TAG_BITS-1:0] o_tag,
   output logic                o_val,
   input  logic                i_rdy,
   output logic                o_err
);

   localparam int N = DAT_BITS / WORD_BITS;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [WORD_BITS-1:0] NPRIME = MONT_FACTOR[WORD_BITS-1:0];

   if (DAT_BITS % WORD_BITS != 0) begin : g_width_check
      $fatal(1, "fe_mont_mul_ws: DAT_BITS must be a multiple of WORD_BITS");
   end

   mont_state_t          state;
   logic [DAT_BITS-1:0]  a_reg;
   logic [DAT_BITS-1:0]  b_reg;
   logic [TAG_BITS-1:0]  tag_reg;
   logic [CNT_W-1:0]     cnt;
   logic [DAT_BITS:0]    t_reg;
   logic [DAT_BITS:0]    t_next;
   logic [WORD_BITS-1:0] a_word;
   logic [DAT_BITS-1:0]  result;
   logic                 accept;

   assign accept = (state == ST_IDLE) && i_val && o_rdy;
   assign a_word = a_reg[cnt*WORD_BITS +: WORD_BITS];

   mont_word_mac #(
      .DAT_BITS (DAT_BITS),
      .WORD_BITS(WORD_BITS),
      .P        (P),
      .NPRIME   (NPRIME),
      .REG_OUT  (1'b0)
   ) u_mac (
      .clk   (i_clk),
      .rst   (i_rst),
      .t     (t_reg),
      .a_word(a_word),
      .b     (b_reg),
      .t_next(t_next)
   );

   // T < 2P after the last iteration, so one conditional subtract fully reduces.
   always_comb begin
      result = t_reg[DAT_BITS-1:0];
      if (t_reg >= {1'b0, P}) result = DAT_BITS'(t_reg - {1'b0, P});
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= ST_IDLE;
         o_rdy   <= 1'b0;
         o_val   <= 1'b0;
         o_dat   <= '0;
         o_tag   <= '0;
         cnt     <= '0;
         t_reg   <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         tag_reg <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_reg   <= i_a;
                  b_reg   <= i_b;
                  tag_reg <= i_tag;
                  t_reg   <= '0;
                  cnt     <= '0;
                  o_rdy   <= 1'b0;
                  state   <= ST_ITER;
               end else begin
                  o_rdy <= 1'b1;
               end
            end
            ST_ITER: begin
               t_reg <= t_next;
               if (cnt == CNT_W'(N-1)) begin
                  cnt   <= '0;
                  state <= ST_FINAL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FINAL: begin
               o_dat <= result;
               o_tag <= tag_reg;
               o_val <= 1'b1;
               state <= ST_OUT;
            end
            ST_OUT: begin
               if (i_rdy) begin
                  o_val <= 1'b0;
                  o_rdy <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef FE_MONT_MUL_SELF_CHECK_EN
   function automatic logic [DAT_BITS-1:0] ref_mont(input logic [DAT_BITS-1:0] a,
                                                    input logic [DAT_BITS-1:0] b);
      logic [DAT_BITS+1:0] t;
      t = '0;
      for (int i = 0; i < DAT_BITS; i++) begin
         if (a[i]) t = t + {2'b00, b};
         if (t[0]) t = t + {2'b00, P};
         t = t >> 1;
      end
      if (t >= {2'b00, P}) t = t - {2'b00, P};
      return t[DAT_BITS-1:0];
   endfunction

   logic [DAT_BITS-1:0] expect_reg;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         expect_reg <= '0;
         o_err      <= 1'b0;
      end else begin
         if (accept) expect_reg <= ref_mont(i_a, i_b);
         if (state == ST_FINAL && result != expect_reg) begin
            o_err <= 1'b1;
            $error("fe_mont_mul_ws: result %h differs from reference %h", result, expect_reg);
         end
      end
   end
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fe_mont_mul_ws.sv
// Directed bench for fe_mont_mul_ws: reset, known Montgomery vectors, corners,
// backpressure, back-to-back streaming and reset during an operation.
module tb_fe_mont_mul_ws;
   import bn128_pkg::*;

   localparam fe_t R_MOD_P = 256'h0e0a77c19a07df2f666ea36f7879462c0a78eb28f5c70b3dd35d438dc58f0d9d;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   fe_t        i_a = '0;
   fe_t        i_b = '0;
   logic [7:0] i_tag = '0;
   logic       i_val = 1'b0;
   logic       o_rdy;
   fe_t        o_dat;
   logic [7:0] o_tag;
   logic       o_val;
   logic       i_rdy = 1'b1;
   logic       o_err;

   int checks = 0;
   int errors = 0;
   longint cycle = 0;

   fe_t        exp_q[$];
   logic [7:0] tag_q[$];

   fe_mont_mul_ws dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_a  (i_a),
      .i_b  (i_b),
      .i_tag(i_tag),
      .i_val(i_val),
      .o_rdy(o_rdy),
      .o_dat(o_dat),
      .o_tag(o_tag),
      .o_val(o_val),
      .i_rdy(i_rdy),
      .o_err(o_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   function automatic fe_t rand_fe();
      fe_t v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      v[255:253] = 3'b000;
      return v;
   endfunction

   // Issues one operation; lat is accept-to-o_val cycles or -1 on timeout.
   task automatic run_op(input fe_t a, input fe_t b, input logic [7:0] tag,
                         output fe_t dat, output logic [7:0] tag_out, output int lat);
      int guard;
      guard = 0;
      while (!o_rdy && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      i_a = a; i_b = b; i_tag = tag; i_val = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      lat = 0;
      while (!o_val && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      dat = o_dat;
      tag_out = o_tag;
      if (!o_val) lat = -1;
      $display("op tag=%h a=%h b=%h -> dat=%h tag=%h lat=%0d", tag, a, b, dat, tag_out, lat);
      if (o_val && i_rdy) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", o_rdy); end
      checks++; if (o_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", o_val); end
      checks++; if (o_dat !== '0) begin errors++; $display("FAIL reset_dat got %h want 0", o_dat); end
      checks++; if (o_tag !== 8'h00) begin errors++; $display("FAIL reset_tag got %h want 00", o_tag); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy_after got %b want 1", o_rdy); end
      $display("reset done");
   endtask

   task automatic test_recip_sq();
      fe_t dat; logic [7:0] tg; int lat;
      run_op(MONT_RECIP_SQ, fe_t'(1), 8'h5A, dat, tg, lat);
      checks++; if (dat !== R_MOD_P) begin errors++; $display("FAIL recip_sq_dat got %h want %h", dat, R_MOD_P); end
      checks++; if (tg !== 8'h5A) begin errors++; $display("FAIL recip_sq_tag got %h want 5a", tg); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL recip_sq_latency got %0d want 5", lat); end
   endtask

   task automatic test_roundtrip();
      fe_t dat, dat2; logic [7:0] tg; int lat;
      run_op(fe_to_mont(fe_t'(3)), fe_to_mont(fe_t'(4)), 8'h01, dat, tg, lat);
      checks++; if (dat !== fe_to_mont(fe_t'(12))) begin errors++; $display("FAIL mont_3x4 got %h want %h", dat, fe_to_mont(fe_t'(12))); end
      run_op(dat, fe_t'(1), 8'h02, dat2, tg, lat);
      checks++; if (dat2 !== fe_t'(12)) begin errors++; $display("FAIL from_mont_12 got %h want %h", dat2, fe_t'(12)); end
   endtask

   task automatic test_corners();
      fe_t dat_mm, dat_z, dat_one; logic [7:0] tg; int lat;
      run_op(P - 1, P - 1, 8'h10, dat_mm, tg, lat);
      checks++; if (dat_mm !== fe_mul_mont(P - 1, P - 1)) begin errors++; $display("FAIL corner_pm1 got %h want %h", dat_mm, fe_mul_mont(P - 1, P - 1)); end
      checks++; if (!(dat_mm < P)) begin errors++; $display("FAIL corner_pm1_range got %h want below %h", dat_mm, P); end
      run_op(fe_t'(0), P - 1, 8'h11, dat_z, tg, lat);
      checks++; if (dat_z !== fe_t'(0)) begin errors++; $display("FAIL corner_zero got %h want 0", dat_z); end
      checks++; if (lat !== 5) begin errors++; $display("FAIL corner_zero_latency got %0d want 5", lat); end
      run_op(fe_t'(1), fe_t'(1), 8'h12, dat_one, tg, lat);
      checks++; if (dat_one !== fe_mul_mont(fe_t'(1), fe_t'(1))) begin errors++; $display("FAIL corner_one got %h want %h", dat_one, fe_mul_mont(fe_t'(1), fe_t'(1))); end
      // (-1)*(-1) and 1*1 both reduce to R^-1 mod P
      checks++; if (dat_one !== dat_mm) begin errors++; $display("FAIL corner_rinv got %h want %h", dat_one, dat_mm); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL corner_err got %b want 0", o_err); end
   endtask

   task automatic test_backpressure();
      fe_t dat, expv; logic [7:0] tg; int lat;
      expv = fe_mul_mont(fe_t'(7), fe_t'(9));
      i_rdy = 1'b0;
      run_op(fe_t'(7), fe_t'(9), 8'hC3, dat, tg, lat);
      checks++; if (dat !== expv) begin errors++; $display("FAIL bp_dat got %h want %h", dat, expv); end
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         checks++;
         if (o_val !== 1'b1 || o_rdy !== 1'b0 || o_dat !== expv || o_tag !== 8'hC3) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got val=%b rdy=%b dat=%h tag=%h want val=1 rdy=0 dat=%h tag=c3",
                     k, o_val, o_rdy, o_dat, o_tag, expv);
         end
      end
      i_rdy = 1'b1;
      @(posedge clk); #1;
      checks++; if (o_val !== 1'b0 || o_rdy !== 1'b1) begin errors++; $display("FAIL bp_release got val=%b rdy=%b want val=0 rdy=1", o_val, o_rdy); end
      $display("backpressure done");
   endtask

   task automatic test_back_to_back();
      int got, timeout;
      longint last;
      exp_q.delete(); tag_q.delete();
      got = 0; timeout = 0; last = 0;
      i_rdy = 1'b1;
      fork
         begin
            for (int k = 0; k < 1000; k++) begin
               fe_t a, b;
               int g;
               a = rand_fe(); b = rand_fe();
               exp_q.push_back(fe_mul_mont(a, b));
               tag_q.push_back(8'(k));
               i_a = a; i_b = b; i_tag = 8'(k); i_val = 1'b1;
               g = 0;
               while (!o_rdy && g < 20) begin
                  @(posedge clk); #1; g++;
               end
               @(posedge clk); #1;
            end
            i_val = 1'b0;
         end
         begin
            while (got < 1000 && timeout < 9000) begin
               @(posedge clk); #1; timeout++;
               if (o_val) begin
                  fe_t ev; logic [7:0] et;
                  if (exp_q.size() == 0) begin
                     checks++; errors++;
                     $display("FAIL b2b_unexpected got dat=%h want no result", o_dat);
                  end else begin
                     ev = exp_q.pop_front(); et = tag_q.pop_front();
                     checks++; if (o_dat !== ev) begin errors++; $display("FAIL b2b_dat idx %0d got %h want %h", got, o_dat, ev); end
                     checks++; if (o_tag !== et) begin errors++; $display("FAIL b2b_tag idx %0d got %h want %h", got, o_tag, et); end
                  end
                  if (got > 0) begin
                     checks++; if (cycle - last != 7) begin errors++; $display("FAIL b2b_spacing idx %0d got %0d want 7", got, cycle - last); end
                  end
                  $display("b2b %0d dat=%h tag=%h", got, o_dat, o_tag);
                  last = cycle;
                  got++;
               end
            end
         end
      join
      checks++; if (got != 1000) begin errors++; $display("FAIL b2b_count got %0d want 1000", got); end
   endtask

   task automatic test_reset_mid();
      fe_t dat; logic [7:0] tg; int lat; int seen;
      i_rdy = 1'b1;
      i_a = fe_to_mont(fe_t'(6)); i_b = fe_to_mont(fe_t'(7)); i_tag = 8'h77; i_val = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++; if (o_val !== 1'b0 || o_rdy !== 1'b0) begin errors++; $display("FAIL midrst_assert got val=%b rdy=%b want val=0 rdy=0", o_val, o_rdy); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy got %b want 1", o_rdy); end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (o_val) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_output got %0d results want 0", seen); end
      run_op(fe_to_mont(fe_t'(2)), fe_to_mont(fe_t'(5)), 8'h2A, dat, tg, lat);
      checks++; if (dat !== fe_to_mont(fe_t'(10))) begin errors++; $display("FAIL midrst_next got %h want %h", dat, fe_to_mont(fe_t'(10))); end
      checks++; if (tg !== 8'h2A || lat !== 5) begin errors++; $display("FAIL midrst_next_meta got tag=%h lat=%0d want tag=2a lat=5", tg, lat); end
   endtask

   initial begin
      test_reset();
      test_recip_sq();
      test_roundtrip();
      test_corners();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
